// File: rtl/ibex_wb_arbiter_pkg.sv
// Shared types and constants for the writeback register-file write-port arbiter.
package ibex_wb_arbiter_pkg;

    typedef enum logic {
        WB_RF_INT = 1'b0,
        WB_RF_FP  = 1'b1
    } wb_rf_sel_e;

    typedef struct packed {
        logic       valid;
        wb_rf_sel_e sel;
        logic [4:0] waddr;
        logic [31:0] wdata;
    } wb_req_t;

    localparam int unsigned WB_ARB_CNT_W = 4;
    // Per-port candidates in fixed rank order: LSU, skid, first core requester, second core requester
    localparam int unsigned WB_ARB_NREQ  = 4;

    // Integer writes to x0 are architecturally discarded
    function automatic logic is_x0(input wb_rf_sel_e sel, input logic [4:0] waddr);
        return (sel == WB_RF_INT) && (waddr == 5'd0);
    endfunction

endpackage

// File: rtl/ibex_wb_arbiter_if.sv
// Bundle of producer requests, RF write ports and hazard/perf outputs of the writeback arbiter.
interface ibex_wb_arbiter_if;

    logic        lsu_we_i;
    logic        lsu_to_fp_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;

    logic        ex_valid_i;
    logic        ex_to_fp_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_ready_o;

    logic        fpu_valid_i;
    logic        fpu_to_fp_i;
    logic [4:0]  fpu_waddr_i;
    logic [31:0] fpu_wdata_i;
    logic        fpu_ready_o;

    logic        rf_we_int_o;
    logic [4:0]  rf_waddr_int_o;
    logic [31:0] rf_wdata_int_o;
    logic        rf_we_fp_o;
    logic [4:0]  rf_waddr_fp_o;
    logic [31:0] rf_wdata_fp_o;

    logic        pend_valid_o;
    logic        pend_to_fp_o;
    logic [4:0]  pend_waddr_o;
    logic        arb_stall_o;

    // Arbiter side
    modport slave (
        input  lsu_we_i, lsu_to_fp_i, lsu_waddr_i, lsu_wdata_i,
        input  ex_valid_i, ex_to_fp_i, ex_waddr_i, ex_wdata_i,
        input  fpu_valid_i, fpu_to_fp_i, fpu_waddr_i, fpu_wdata_i,
        output ex_ready_o, fpu_ready_o,
        output rf_we_int_o, rf_waddr_int_o, rf_wdata_int_o,
        output rf_we_fp_o, rf_waddr_fp_o, rf_wdata_fp_o,
        output pend_valid_o, pend_to_fp_o, pend_waddr_o, arb_stall_o
    );

    // Producer / register-file side
    modport master (
        output lsu_we_i, lsu_to_fp_i, lsu_waddr_i, lsu_wdata_i,
        output ex_valid_i, ex_to_fp_i, ex_waddr_i, ex_wdata_i,
        output fpu_valid_i, fpu_to_fp_i, fpu_waddr_i, fpu_wdata_i,
        input  ex_ready_o, fpu_ready_o,
        input  rf_we_int_o, rf_waddr_int_o, rf_wdata_int_o,
        input  rf_we_fp_o, rf_waddr_fp_o, rf_wdata_fp_o,
        input  pend_valid_o, pend_to_fp_o, pend_waddr_o, arb_stall_o
    );

endinterface

// File: rtl/ibex_wb_arbiter_port_arb.sv
// Combinational fixed-priority select for one RF write port; index 0 ranks highest.
module ibex_wb_port_arb
    import ibex_wb_arbiter_pkg::*;
#(
    parameter wb_rf_sel_e PortSel = WB_RF_INT
) (
    input  wb_req_t [WB_ARB_NREQ-1:0] req_i,
    output logic    [WB_ARB_NREQ-1:0] gnt_o,
    output logic                      we_o,
    output logic    [4:0]             waddr_o,
    output logic    [31:0]            wdata_o
);

    // Walk from lowest to highest rank so the highest-ranked request targeting this port wins
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise the no-request path infers latches.
        gnt_o   = '0;
        we_o    = 1'b0;
        waddr_o = '0;
        wdata_o = '0;
        for (int i = WB_ARB_NREQ - 1; i >= 0; i--) begin
            if (req_i[i].valid && (req_i[i].sel == PortSel)) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                we_o     = 1'b1;
                waddr_o  = req_i[i].waddr;
                wdata_o  = req_i[i].wdata;
            end
        end
    end

endmodule

// File: rtl/ibex_wb_arbiter.sv
// Writeback RF write-port arbiter: LSU, ID/EX and FPU share the integer and FP write ports.
// Optional one-entry FPU skid buffer compiled in with `define IBEX_WB_ARB_SKID_EN.
module ibex_wb_arbiter
    import ibex_wb_arbiter_pkg::*;
#(
    parameter int unsigned StarveLimit = 3,
    parameter bit          ResetAll    = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ibex_wb_arbiter_if.slave bus
);

    localparam logic [WB_ARB_CNT_W-1:0] StarveMax = WB_ARB_CNT_W'(StarveLimit);

    wb_req_t                   lsu_req, ex_req, fpu_req, skid_req;
    wb_req_t [WB_ARB_NREQ-1:0] req_vec;
    logic    [WB_ARB_NREQ-1:0] gnt_int, gnt_fp;
    logic                      ex_x0, fpu_x0, promote;
    logic                      ex_win, fpu_win, fpu_ready, ex_ready;
    logic                      we_int, we_fp;
    logic    [4:0]             waddr_int, waddr_fp;
    logic    [31:0]            wdata_int, wdata_fp;
    logic    [WB_ARB_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                      skid_full;

`ifdef IBEX_WB_ARB_SKID_EN
    logic        skid_valid_q, skid_valid_d, skid_win, fpu_capture;
    wb_rf_sel_e  skid_sel_q;
    logic [4:0]  skid_waddr_q;
    logic [31:0] skid_wdata_q;
    logic        unused_gnt;

    assign skid_full  = skid_valid_q;
    assign unused_gnt = ^{gnt_int[0], gnt_fp[0]};
`else
    logic unused_gnt, unused_cfg;

    assign skid_full  = 1'b0;
    assign unused_gnt = ^{gnt_int[1:0], gnt_fp[1:0]};
    assign unused_cfg = ResetAll;
`endif

    // Qualify requests: nothing reaches a port during reset, and integer x0 writes never occupy one
    always_comb begin
        ex_x0   = is_x0(wb_rf_sel_e'(bus.ex_to_fp_i), bus.ex_waddr_i);
        fpu_x0  = is_x0(wb_rf_sel_e'(bus.fpu_to_fp_i), bus.fpu_waddr_i);
        lsu_req = '{valid: ~rst_i & bus.lsu_we_i & ~is_x0(wb_rf_sel_e'(bus.lsu_to_fp_i), bus.lsu_waddr_i),
                    sel: wb_rf_sel_e'(bus.lsu_to_fp_i), waddr: bus.lsu_waddr_i, wdata: bus.lsu_wdata_i};
        ex_req  = '{valid: ~rst_i & bus.ex_valid_i & ~ex_x0,
                    sel: wb_rf_sel_e'(bus.ex_to_fp_i), waddr: bus.ex_waddr_i, wdata: bus.ex_wdata_i};
        // A held FPU result blocks new FPU results, even in the cycle it drains
        fpu_req = '{valid: ~rst_i & bus.fpu_valid_i & ~fpu_x0 & ~skid_full,
                    sel: wb_rf_sel_e'(bus.fpu_to_fp_i), waddr: bus.fpu_waddr_i, wdata: bus.fpu_wdata_i};
`ifdef IBEX_WB_ARB_SKID_EN
        skid_req = '{valid: ~rst_i & skid_valid_q, sel: skid_sel_q, waddr: skid_waddr_q, wdata: skid_wdata_q};
`else
        skid_req = '{valid: 1'b0, sel: WB_RF_INT, waddr: '0, wdata: '0};
`endif
        promote = (starve_cnt_q == StarveMax);
        req_vec = promote ? {ex_req, fpu_req, skid_req, lsu_req}
                          : {fpu_req, ex_req, skid_req, lsu_req};
    end

    ibex_wb_port_arb #(.PortSel(WB_RF_INT)) u_port_int (
        .req_i   (req_vec),
        .gnt_o   (gnt_int),
        .we_o    (we_int),
        .waddr_o (waddr_int),
        .wdata_o (wdata_int)
    );

    ibex_wb_port_arb #(.PortSel(WB_RF_FP)) u_port_fp (
        .req_i   (req_vec),
        .gnt_o   (gnt_fp),
        .we_o    (we_fp),
        .waddr_o (waddr_fp),
        .wdata_o (wdata_fp)
    );

    assign ex_win   = promote ? (gnt_int[3] | gnt_fp[3]) : (gnt_int[2] | gnt_fp[2]);
    assign fpu_win  = promote ? (gnt_int[2] | gnt_fp[2]) : (gnt_int[3] | gnt_fp[3]);
    assign ex_ready = ~rst_i & bus.ex_valid_i & (ex_x0 | ex_win);

`ifdef IBEX_WB_ARB_SKID_EN
    assign fpu_ready    = ~rst_i & ~skid_valid_q;
    assign skid_win     = gnt_int[1] | gnt_fp[1];
    assign fpu_capture  = fpu_req.valid & ~fpu_win;
    assign skid_valid_d = skid_valid_q ? ~skid_win : fpu_capture;

    // Skid occupancy: set by a losing FPU result, cleared once its port is free of LSU traffic
    always_ff @(posedge clk_i) begin
        if (rst_i) skid_valid_q <= 1'b0;
        else       skid_valid_q <= skid_valid_d;
    end

    // Skid payload: qualified by skid_valid_q, so clearing it on reset is optional
    always_ff @(posedge clk_i) begin
        if (ResetAll && rst_i) begin
            skid_sel_q   <= WB_RF_INT;
            skid_waddr_q <= '0;
            skid_wdata_q <= '0;
        end else if (fpu_capture) begin
            skid_sel_q   <= fpu_req.sel;
            skid_waddr_q <= fpu_req.waddr;
            skid_wdata_q <= fpu_req.wdata;
        end
    end

    assign bus.pend_valid_o = ~rst_i & skid_valid_q;
    assign bus.pend_to_fp_o = (skid_sel_q == WB_RF_FP);
    assign bus.pend_waddr_o = skid_waddr_q;
`else
    assign fpu_ready        = ~rst_i & bus.fpu_valid_i & (fpu_x0 | fpu_win);
    assign bus.pend_valid_o = 1'b0;
    assign bus.pend_to_fp_o = 1'b0;
    assign bus.pend_waddr_o = '0;
`endif

    // Starvation counter next state: consecutive FPU stall cycles, saturating at the limit
    always_comb begin
        starve_cnt_d = '0;
        if (bus.fpu_valid_i && !fpu_ready) begin
            starve_cnt_d = promote ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst_i) starve_cnt_q <= '0;
        else       starve_cnt_q <= starve_cnt_d;
    end

    assign bus.ex_ready_o     = ex_ready;
    assign bus.fpu_ready_o    = fpu_ready;
    assign bus.arb_stall_o    = ~rst_i & ((bus.ex_valid_i & ~ex_ready) | (bus.fpu_valid_i & ~fpu_ready));
    assign bus.rf_we_int_o    = we_int;
    assign bus.rf_waddr_int_o = waddr_int;
    assign bus.rf_wdata_int_o = wdata_int;
    assign bus.rf_we_fp_o     = we_fp;
    assign bus.rf_waddr_fp_o  = waddr_fp;
    assign bus.rf_wdata_fp_o  = wdata_fp;

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Self-checking bench for ibex_wb_arbiter: directed scenarios then randomized traffic,
// every cycle compared against a rule-level reference model.
module tb_ibex_wb_arbiter;
    import ibex_wb_arbiter_pkg::*;

    localparam int LIMIT = 3;
`ifdef IBEX_WB_ARB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibex_wb_arbiter_if bus();

    ibex_wb_arbiter #(.StarveLimit(LIMIT), .ResetAll(1'b0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit        m_skid_v, m_skid_fp;
    bit [4:0]  m_skid_addr;
    bit [31:0] m_skid_data;
    int        m_cnt;
    bit        n_skid_v, n_skid_fp;
    bit [4:0]  n_skid_addr;
    bit [31:0] n_skid_data;
    int        n_cnt;

    // Expected outputs for the current cycle (port 0 = integer, port 1 = FP)
    bit        e_we [2];
    bit [4:0]  e_addr [2];
    bit [31:0] e_data [2];
    bit        e_ex_ready, e_fpu_ready, e_stall, e_pend_v, e_pend_fp;
    bit [4:0]  e_pend_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Producers: 0 LSU, 1 held FPU result, 2 EX, 3 FPU. Each port goes to the first
    // producer in rank order that wants it; FPU moves ahead of EX once starved.
    task automatic model_eval();
        bit        want [4];
        int        port [4];
        bit [4:0]  addr [4];
        bit [31:0] data [4];
        int        order [4];
        int        winner [2];
        bit        ex_x0, fpu_x0, ex_won, fpu_won, skid_won;

        ex_x0  = !bus.ex_to_fp_i && (bus.ex_waddr_i == 5'd0);
        fpu_x0 = !bus.fpu_to_fp_i && (bus.fpu_waddr_i == 5'd0);

        want[0] = bus.lsu_we_i && !(!bus.lsu_to_fp_i && bus.lsu_waddr_i == 5'd0);
        port[0] = int'(bus.lsu_to_fp_i); addr[0] = bus.lsu_waddr_i; data[0] = bus.lsu_wdata_i;
        want[1] = m_skid_v;
        port[1] = int'(m_skid_fp); addr[1] = m_skid_addr; data[1] = m_skid_data;
        want[2] = bus.ex_valid_i && !ex_x0;
        port[2] = int'(bus.ex_to_fp_i); addr[2] = bus.ex_waddr_i; data[2] = bus.ex_wdata_i;
        want[3] = bus.fpu_valid_i && !fpu_x0 && !(SKID && m_skid_v);
        port[3] = int'(bus.fpu_to_fp_i); addr[3] = bus.fpu_waddr_i; data[3] = bus.fpu_wdata_i;

        if (m_cnt == LIMIT) order = '{0, 1, 3, 2};
        else                order = '{0, 1, 2, 3};

        for (int p = 0; p < 2; p++) begin
            winner[p] = -1;
            for (int k = 0; k < 4; k++)
                if (winner[p] < 0 && want[order[k]] && port[order[k]] == p) winner[p] = order[k];
            e_we[p]   = (winner[p] >= 0);
            e_addr[p] = e_we[p] ? addr[winner[p]] : 5'd0;
            e_data[p] = e_we[p] ? data[winner[p]] : 32'd0;
        end
        ex_won   = (winner[0] == 2) || (winner[1] == 2);
        fpu_won  = (winner[0] == 3) || (winner[1] == 3);
        skid_won = (winner[0] == 1) || (winner[1] == 1);

        e_ex_ready  = bus.ex_valid_i && (ex_x0 || ex_won);
        e_fpu_ready = SKID ? !m_skid_v : (bus.fpu_valid_i && (fpu_x0 || fpu_won));
        e_stall     = (bus.ex_valid_i && !e_ex_ready) || (bus.fpu_valid_i && !e_fpu_ready);
        e_pend_v    = SKID && m_skid_v;
        e_pend_fp   = m_skid_fp;
        e_pend_addr = m_skid_addr;

        n_cnt = (bus.fpu_valid_i && !e_fpu_ready) ? ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1) : 0;
        n_skid_v = m_skid_v; n_skid_fp = m_skid_fp; n_skid_addr = m_skid_addr; n_skid_data = m_skid_data;
        if (m_skid_v) begin
            if (skid_won) n_skid_v = 1'b0;
        end else if (SKID && want[3] && !fpu_won) begin
            n_skid_v = 1'b1; n_skid_fp = bus.fpu_to_fp_i;
            n_skid_addr = bus.fpu_waddr_i; n_skid_data = bus.fpu_wdata_i;
        end

        if (rst) begin
            e_we = '{0, 0};
            e_ex_ready = 0; e_fpu_ready = 0; e_stall = 0; e_pend_v = 0;
            n_cnt = 0; n_skid_v = 0;
        end
    endtask

    task automatic compare();
        check("we_int", bus.rf_we_int_o, e_we[0]);
        if (e_we[0]) begin
            check("waddr_int", bus.rf_waddr_int_o, e_addr[0]);
            check("wdata_int", bus.rf_wdata_int_o, e_data[0]);
        end
        check("we_fp", bus.rf_we_fp_o, e_we[1]);
        if (e_we[1]) begin
            check("waddr_fp", bus.rf_waddr_fp_o, e_addr[1]);
            check("wdata_fp", bus.rf_wdata_fp_o, e_data[1]);
        end
        check("ex_ready", bus.ex_ready_o, e_ex_ready);
        check("fpu_ready", bus.fpu_ready_o, e_fpu_ready);
        check("arb_stall", bus.arb_stall_o, e_stall);
        check("pend_valid", bus.pend_valid_o, e_pend_v);
        if (e_pend_v) begin
            check("pend_to_fp", bus.pend_to_fp_o, e_pend_fp);
            check("pend_waddr", bus.pend_waddr_o, e_pend_addr);
        end
`ifndef IBEX_WB_ARB_SKID_EN
        check("pend_to_fp_tied", bus.pend_to_fp_o, 0);
        check("pend_waddr_tied", bus.pend_waddr_o, 0);
`endif
    endtask

    // Called just after the negedge once inputs are set: settle, compare, advance the model
    task automatic drive_check();
        #1;
        model_eval();
        compare();
        m_cnt = n_cnt; m_skid_v = n_skid_v; m_skid_fp = n_skid_fp;
        m_skid_addr = n_skid_addr; m_skid_data = n_skid_data;
    endtask

    task automatic set_lsu(input bit we, input bit fp, input bit [4:0] a, input bit [31:0] d);
        bus.lsu_we_i = we; bus.lsu_to_fp_i = fp; bus.lsu_waddr_i = a; bus.lsu_wdata_i = d;
    endtask
    task automatic set_ex(input bit v, input bit fp, input bit [4:0] a, input bit [31:0] d);
        bus.ex_valid_i = v; bus.ex_to_fp_i = fp; bus.ex_waddr_i = a; bus.ex_wdata_i = d;
    endtask
    task automatic set_fpu(input bit v, input bit fp, input bit [4:0] a, input bit [31:0] d);
        bus.fpu_valid_i = v; bus.fpu_to_fp_i = fp; bus.fpu_waddr_i = a; bus.fpu_wdata_i = d;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst = 1'b1;
        set_lsu(0, 0, 0, 0); set_ex(0, 0, 0, 0); set_fpu(0, 0, 0, 0);
        drive_check();
    endtask

    function automatic bit [4:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        bit last_rst, last_ex_ready, last_fpu_acc;

        // Reset held with every requester active: nothing written, nothing ready
        set_lsu(1, 0, 5'd3, 32'h1); set_ex(1, 0, 5'd5, 32'h1234); set_fpu(1, 1, 5'd6, 32'h2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            drive_check();
            check("rst_we_int", bus.rf_we_int_o, 0);
            check("rst_we_fp", bus.rf_we_fp_o, 0);
            check("rst_ex_ready", bus.ex_ready_o, 0);
            check("rst_fpu_ready", bus.fpu_ready_o, 0);
            check("rst_stall", bus.arb_stall_o, 0);
        end

        // Release: EX integer write appears in the same cycle
        @(negedge clk);
        rst = 1'b0;
        set_lsu(0, 0, 0, 0); set_fpu(0, 0, 0, 0); set_ex(1, 0, 5'd5, 32'h1234);
        drive_check();
        check("rel_waddr", bus.rf_waddr_int_o, 5);
        check("rel_wdata", bus.rf_wdata_int_o, 32'h1234);
        check("rel_ex_ready", bus.ex_ready_o, 1);

        // Conflict on the integer port: LSU wins, EX follows next cycle
        @(negedge clk);
        set_lsu(1, 0, 5'd3, 32'hA); set_ex(1, 0, 5'd4, 32'hB);
        drive_check();
        check("cfl_waddr", bus.rf_waddr_int_o, 3);
        check("cfl_wdata", bus.rf_wdata_int_o, 32'hA);
        check("cfl_ex_ready", bus.ex_ready_o, 0);
        check("cfl_stall", bus.arb_stall_o, 1);
        @(negedge clk);
        set_lsu(0, 0, 0, 0);
        drive_check();
        check("cfl2_waddr", bus.rf_waddr_int_o, 4);
        check("cfl2_ex_ready", bus.ex_ready_o, 1);

        // Disjoint ports: both written
        @(negedge clk);
        set_lsu(1, 1, 5'd1, 32'hC); set_ex(1, 0, 5'd2, 32'hD);
        drive_check();
        check("dis_waddr_fp", bus.rf_waddr_fp_o, 1);
        check("dis_waddr_int", bus.rf_waddr_int_o, 2);
        check("dis_stall", bus.arb_stall_o, 0);

        // EX to x0 is accepted without using the port
        @(negedge clk);
        set_lsu(1, 0, 5'd7, 32'h77); set_ex(1, 0, 5'd0, 32'h55);
        drive_check();
        check("x0_ex_ready", bus.ex_ready_o, 1);
        check("x0_waddr", bus.rf_waddr_int_o, 7);
        check("x0_we_fp", bus.rf_we_fp_o, 0);

`ifndef IBEX_WB_ARB_SKID_EN
        // Starvation: FPU loses to EX for LIMIT cycles, then is promoted
        reset_cycle();
        for (int i = 0; i <= LIMIT; i++) begin
            @(negedge clk);
            rst = 1'b0;
            set_ex(1, 1, 5'(10 + i), 32'(100 + i)); set_fpu(1, 1, 5'd20, 32'hF00D);
            drive_check();
            check("stv_fpu_ready", bus.fpu_ready_o, (i == LIMIT) ? 1 : 0);
            check("stv_ex_ready", bus.ex_ready_o, (i == LIMIT) ? 0 : 1);
            check("stv_waddr_fp", bus.rf_waddr_fp_o, (i == LIMIT) ? 20 : 10 + i);
        end
`else
        // Skid: losing FPU result is held, then written ahead of EX
        reset_cycle();
        @(negedge clk);
        rst = 1'b0;
        set_ex(1, 1, 5'd4, 32'h44); set_fpu(1, 1, 5'd9, 32'h99);
        drive_check();
        check("skd_fpu_ready", bus.fpu_ready_o, 1);
        check("skd_waddr_fp", bus.rf_waddr_fp_o, 4);
        @(negedge clk);
        set_ex(1, 1, 5'd5, 32'h55); set_fpu(0, 0, 0, 0);
        drive_check();
        check("skd_pend_valid", bus.pend_valid_o, 1);
        check("skd_pend_waddr", bus.pend_waddr_o, 9);
        check("skd_drain_waddr", bus.rf_waddr_fp_o, 9);
        check("skd_drain_ex", bus.ex_ready_o, 0);
        check("skd_drain_fpu", bus.fpu_ready_o, 0);
        @(negedge clk);
        drive_check();
        check("skd_after_ex", bus.ex_ready_o, 1);
        check("skd_after_pend", bus.pend_valid_o, 0);
`endif

        // Randomized traffic with occasional mid-run reset; producers obey hold-until-ready
        reset_cycle();
        last_rst = 1'b1; last_ex_ready = 1'b0; last_fpu_acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            if (last_rst || !bus.ex_valid_i || last_ex_ready)
                set_ex($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
            if (last_rst || !bus.fpu_valid_i || last_fpu_acc)
                set_fpu($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
            set_lsu($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
            drive_check();
            last_rst      = rst;
            last_ex_ready = e_ex_ready;
            last_fpu_acc  = bus.fpu_valid_i && e_fpu_ready;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
